// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and sends each one as an asynchronous 8N1 frame on o_tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int c_CLKDIV    = 104,
  parameter int c_DATAWIDTH = 8
) (
  input  logic                   i_clock,
  input  logic                   i_resetn,
  input  logic [c_DATAWIDTH-1:0] i_fifo_data,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_readen,
  input  logic                   i_enable,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int BAUD_W = (c_CLKDIV > 1) ? $clog2(c_CLKDIV) : 1;
  localparam int BIT_W  = (c_DATAWIDTH > 1) ? $clog2(c_DATAWIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(c_CLKDIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(c_DATAWIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state_reg;
  logic [BAUD_W-1:0]      baud_reg;
  logic [BIT_W-1:0]       bit_reg;
  logic [c_DATAWIDTH-1:0] shift_reg;
  logic                   fifo_readen_reg;
  logic                   tx_reg;
  logic                   busy_reg;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   parity_reg;
`endif

  logic pop;
  logic baud_done;

  // The pop is decided only from IDLE, so empty is never looked at again until the frame is over.
  assign pop       = (state_reg == IDLE) && i_enable && !i_fifo_empty;
  assign baud_done = (baud_reg == BAUD_LAST);

  // state_reg runs one cycle ahead of the line: o_tx/o_busy are registered from it,
  // which keeps the line glitch-free and makes the first start-bit cycle follow the pop cycle.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state_reg       <= IDLE;
      baud_reg        <= '0;
      bit_reg         <= '0;
      shift_reg       <= '0;
      fifo_readen_reg <= 1'b0;
      tx_reg          <= 1'b1;
      busy_reg        <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      fifo_readen_reg <= pop;
      busy_reg        <= pop || (state_reg != IDLE);

      case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[0];
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY:  tx_reg <= parity_reg;
`endif
        default: tx_reg <= 1'b1;
      endcase

      if ((state_reg == IDLE) || baud_done) begin
        baud_reg <= '0;
      end else begin
        baud_reg <= baud_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg <= i_fifo_data;
            bit_reg   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= ^i_fifo_data;
`endif
            state_reg <= START;
          end
        end
        START: begin
          if (baud_done) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (baud_done) begin
            shift_reg <= shift_reg >> 1;
            if (bit_reg == BIT_LAST) begin
              bit_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state_reg <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_fifo_readen = fifo_readen_reg;
  assign o_tx          = tx_reg;
  assign o_busy        = busy_reg;

endmodule
